dma_engine: RTL and testbench

DMA_ENGINE -- requirements
Module: dma_engine

---
 rtl/dma_engine.sv | 191 +++++++++++++++++++
 tb/tb_dma_engine.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_engine.sv
// dma_engine: single-channel memory-to-memory DMA over AXI, copying
// DMALEN words from DMASRC to DMADST in bursts of up to BURST_MAX beats.
// Ports: clk/rst (async, active-low); DMAEN/DMASRC/DMADST/DMALEN config;
// M_AR*/M_R*/M_AW*/M_W*/M_B* AXI master channels; DMA_BUSY/DMA_DONE status.
module dma_engine #(
  parameter int         BURST_MAX = 16,
  parameter logic [3:0] MST_ID    = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        DMAEN,
  input  logic [31:0] DMASRC,
  input  logic [31:0] DMADST,
  input  logic [31:0] DMALEN,
  output logic [3:0]  M_ARID,
  output logic [31:0] M_ARAddr,
  output logic [3:0]  M_ARLen,
  output logic [2:0]  M_ARSize,
  output logic [1:0]  M_ARBurst,
  output logic        M_ARValid,
  input  logic        M_ARReady,
  input  logic [3:0]  M_RID,
  input  logic [31:0] M_RData,
  input  logic [1:0]  M_RResp,
  input  logic        M_RLast,
  input  logic        M_RValid,
  output logic        M_RReady,
  output logic [3:0]  M_AWID,
  output logic [31:0] M_AWAddr,
  output logic [3:0]  M_AWLen,
  output logic [2:0]  M_AWSize,
  output logic [1:0]  M_AWBurst,
  output logic        M_AWValid,
  input  logic        M_AWReady,
  output logic [31:0] M_WData,
  output logic [3:0]  M_WStrb,
  output logic        M_WLast,
  output logic        M_WValid,
  input  logic        M_WReady,
  input  logic [3:0]  M_BID,
  input  logic [1:0]  M_BResp,
  input  logic        M_BValid,
  output logic        M_BReady,
  output logic        DMA_BUSY,
  output logic        DMA_DONE
);

  localparam int         IW   = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
  localparam logic [4:0] BMAX = 5'(BURST_MAX);

  typedef enum logic [2:0] {
    IDLE, RADDR, RDATA, WADDR, WDATA, WRESP, DONE
  } state_t;

  state_t      state, state_n;
  logic        en_d;
  logic [31:0] src, dst, rem;
  logic [4:0]  blen, beat;
  logic [31:0] buffer [BURST_MAX];

  logic        start, r_hs, w_hs, last_w;
  logic [4:0]  blen_m1;
  logic [31:0] rem_n, step;

  // Response IDs/codes are intentionally not used for flow control.
  logic unused;
  assign unused = ^{M_RID, M_RResp, M_BID, M_BResp};

  assign start   = DMAEN & ~en_d;
  assign blen_m1 = blen - 5'd1;
  assign last_w  = (beat == blen_m1);
  assign r_hs    = (state == RDATA) & M_RValid;
  assign w_hs    = (state == WDATA) & M_WReady;
  assign step    = {25'd0, blen, 2'b00};
  assign rem_n   = rem - {27'd0, blen};

  function automatic logic [4:0] burst_of(input logic [31:0] r);
    if (r >= 32'(BURST_MAX)) return BMAX;
    return r[4:0];
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // Payload outputs are forced to zero outside their valid phase so that
  // the bus is quiet in idle and during reset.
  always_comb begin
    state_n   = state;
    M_ARValid = 1'b0;
    M_RReady  = 1'b0;
    M_AWValid = 1'b0;
    M_WValid  = 1'b0;
    M_BReady  = 1'b0;
    DMA_BUSY  = 1'b1;
    DMA_DONE  = 1'b0;
    case (state)
      IDLE: begin
        DMA_BUSY = 1'b0;
        if (start) state_n = (DMALEN == 32'd0) ? DONE : RADDR;
      end
      RADDR: begin
        M_ARValid = 1'b1;
        if (M_ARReady) state_n = RDATA;
      end
      RDATA: begin
        M_RReady = 1'b1;
        if (M_RValid && M_RLast) state_n = WADDR;
      end
      WADDR: begin
        M_AWValid = 1'b1;
        if (M_AWReady) state_n = WDATA;
      end
      WDATA: begin
        M_WValid = 1'b1;
        if (M_WReady && last_w) state_n = WRESP;
      end
      WRESP: begin
        M_BReady = 1'b1;
        if (M_BValid) state_n = (rem_n != 32'd0) ? RADDR : DONE;
      end
      DONE: begin
        DMA_BUSY = 1'b0;
        DMA_DONE = 1'b1;
        if (!DMAEN) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign M_ARID    = MST_ID;
  assign M_AWID    = MST_ID;
  assign M_ARAddr  = M_ARValid ? src : 32'd0;
  assign M_ARLen   = M_ARValid ? blen_m1[3:0] : 4'd0;
  assign M_ARSize  = M_ARValid ? 3'b010 : 3'b000;
  assign M_ARBurst = M_ARValid ? 2'b01 : 2'b00;
  assign M_AWAddr  = M_AWValid ? dst : 32'd0;
  assign M_AWLen   = M_AWValid ? blen_m1[3:0] : 4'd0;
  assign M_AWSize  = M_AWValid ? 3'b010 : 3'b000;
  assign M_AWBurst = M_AWValid ? 2'b01 : 2'b00;
  assign M_WData   = M_WValid ? buffer[beat[IW-1:0]] : 32'd0;
  assign M_WStrb   = M_WValid ? 4'hF : 4'h0;
  assign M_WLast   = M_WValid & last_w;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_d <= 1'b0;
      src  <= 32'd0;
      dst  <= 32'd0;
      rem  <= 32'd0;
      blen <= 5'd0;
      beat <= 5'd0;
    end else begin
      en_d <= DMAEN;
      case (state)
        IDLE: begin
          if (start) begin
            src  <= DMASRC & ~32'd3;
            dst  <= DMADST & ~32'd3;
            rem  <= DMALEN;
            blen <= burst_of(DMALEN);
            beat <= 5'd0;
          end
        end
        RDATA: begin
          if (r_hs) beat <= M_RLast ? 5'd0 : beat + 5'd1;
        end
        WDATA: begin
          if (w_hs) beat <= last_w ? 5'd0 : beat + 5'd1;
        end
        WRESP: begin
          if (M_BValid) begin
            src  <= src + step;
            dst  <= dst + step;
            rem  <= rem_n;
            blen <= burst_of(rem_n);
          end
        end
        default: ;
      endcase
    end
  end

  // Extra beats from a misbehaving slave are dropped rather than
  // written past the end of the buffer.
  always_ff @(posedge clk) begin
    if (r_hs && beat < BMAX) buffer[beat[IW-1:0]] <= M_RData;
  end

endmodule

// File: tb/tb_dma_engine.sv
// tb_dma_engine: randomized AXI slave plus queue scoreboard for dma_engine.
// Expected AR/AW/W traffic comes from a burst-splitting model of each copy.
module tb_dma_engine;

  localparam int BM = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        DMAEN;
  logic [31:0] DMASRC, DMADST, DMALEN;
  logic [3:0]  M_ARID, M_ARLen, M_AWID, M_AWLen;
  logic [31:0] M_ARAddr, M_AWAddr, M_WData, M_RData;
  logic [2:0]  M_ARSize, M_AWSize;
  logic [1:0]  M_ARBurst, M_AWBurst, M_RResp, M_BResp;
  logic        M_ARValid, M_ARReady, M_RLast, M_RValid, M_RReady;
  logic        M_AWValid, M_AWReady, M_WLast, M_WValid, M_WReady;
  logic        M_BValid, M_BReady, DMA_BUSY, DMA_DONE;
  logic [3:0]  M_RID, M_BID, M_WStrb;

  always #5 clk = ~clk;

  dma_engine #(.BURST_MAX(BM), .MST_ID(4'd1)) dut (
    .clk(clk), .rst(rst), .DMAEN(DMAEN),
    .DMASRC(DMASRC), .DMADST(DMADST), .DMALEN(DMALEN),
    .M_ARID(M_ARID), .M_ARAddr(M_ARAddr), .M_ARLen(M_ARLen),
    .M_ARSize(M_ARSize), .M_ARBurst(M_ARBurst),
    .M_ARValid(M_ARValid), .M_ARReady(M_ARReady),
    .M_RID(M_RID), .M_RData(M_RData), .M_RResp(M_RResp),
    .M_RLast(M_RLast), .M_RValid(M_RValid), .M_RReady(M_RReady),
    .M_AWID(M_AWID), .M_AWAddr(M_AWAddr), .M_AWLen(M_AWLen),
    .M_AWSize(M_AWSize), .M_AWBurst(M_AWBurst),
    .M_AWValid(M_AWValid), .M_AWReady(M_AWReady),
    .M_WData(M_WData), .M_WStrb(M_WStrb), .M_WLast(M_WLast),
    .M_WValid(M_WValid), .M_WReady(M_WReady),
    .M_BID(M_BID), .M_BResp(M_BResp), .M_BValid(M_BValid),
    .M_BReady(M_BReady), .DMA_BUSY(DMA_BUSY), .DMA_DONE(DMA_DONE)
  );

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct { logic [31:0] addr; logic [3:0] len; } ab_t;
  typedef struct { logic [31:0] data; logic last; } wb_t;

  ab_t exp_ar[$];
  ab_t exp_aw[$];
  wb_t exp_w[$];

  logic [31:0] seed;
  int bp = 100;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ seed;
  endfunction

  function automatic bit coin();
    return $urandom_range(99) < bp;
  endfunction

  // Reference: a copy of n words is a sequence of bursts of at most BM
  // beats; each written word equals the source word at the same offset.
  task automatic model(input logic [31:0] s, input logic [31:0] d,
                       input logic [31:0] n);
    logic [31:0] sa, da, off, b;
    sa  = s & ~32'd3;
    da  = d & ~32'd3;
    off = 0;
    while (off < n) begin
      b = (n - off > BM) ? BM : n - off;
      exp_ar.push_back('{sa + 4 * off, 4'(b - 1)});
      exp_aw.push_back('{da + 4 * off, 4'(b - 1)});
      for (int i = 0; i < int'(b); i++)
        exp_w.push_back('{memword(sa + 4 * (off + i)), i == int'(b) - 1});
      off += b;
    end
  endtask

  // AXI slave: memory returns memword(addr); random back-pressure.
  ab_t rpend[$];
  int  rbeat, bpend;
  bit  r_fire, b_fire;

  initial begin
    M_ARReady = 0; M_AWReady = 0; M_WReady = 0;
    M_RValid = 0; M_RData = 0; M_RLast = 0; M_RResp = 0; M_RID = 0;
    M_BValid = 0; M_BResp = 0; M_BID = 0;
    rbeat = 0; bpend = 0; r_fire = 0; b_fire = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        rpend.delete();
        rbeat = 0; bpend = 0; r_fire = 0; b_fire = 0;
        M_RValid = 0; M_BValid = 0;
        M_ARReady = 0; M_AWReady = 0; M_WReady = 0;
        continue;
      end
      if (r_fire) begin
        if (M_RLast) begin
          void'(rpend.pop_front());
          rbeat = 0;
        end else rbeat++;
        M_RValid = 0;
      end
      if (!M_RValid && rpend.size() > 0 && coin()) begin
        M_RValid = 1;
        M_RData  = memword(rpend[0].addr + 32'(4 * rbeat));
        M_RLast  = (rbeat == int'(rpend[0].len));
        M_RResp  = 2'($urandom);
        M_RID    = 4'($urandom);
      end
      r_fire = M_RValid && M_RReady;
      if (b_fire) begin
        M_BValid = 0;
        bpend--;
      end
      if (!M_BValid && bpend > 0 && coin()) begin
        M_BValid = 1;
        M_BResp  = 2'($urandom);
        M_BID    = 4'($urandom);
      end
      b_fire = M_BValid && M_BReady;
      M_ARReady = coin();
      if (M_ARValid && M_ARReady) rpend.push_back('{M_ARAddr, M_ARLen});
      M_AWReady = coin();
      M_WReady  = coin();
      if (M_WValid && M_WReady && M_WLast) bpend++;
    end
  end

  // Monitor: handshakes decided at this negedge complete at the next
  // posedge; pop and compare, and check held payloads stay stable.
  bit          ar_hold, aw_hold, w_hold;
  logic [35:0] ar_prev, aw_prev;
  logic [32:0] w_prev;

  initial begin
    ar_hold = 0; aw_hold = 0; w_hold = 0;
    forever begin
      ab_t a;
      wb_t w;
      @(negedge clk);
      #1;
      if (!rst) begin
        ar_hold = 0; aw_hold = 0; w_hold = 0;
        continue;
      end
      if (ar_hold)
        check("ar_stable", {M_ARValid, M_ARAddr, M_ARLen}, {1'b1, ar_prev});
      if (aw_hold)
        check("aw_stable", {M_AWValid, M_AWAddr, M_AWLen}, {1'b1, aw_prev});
      if (w_hold)
        check("w_stable", {M_WValid, M_WData, M_WLast}, {1'b1, w_prev});
      if (M_ARValid && M_ARReady) begin
        if (exp_ar.size() == 0) check("ar_unexpected", 1, 0);
        else begin
          a = exp_ar.pop_front();
          check("ar_addr", M_ARAddr, a.addr);
          check("ar_len", M_ARLen, a.len);
          check("ar_id_size_burst", {M_ARID, M_ARSize, M_ARBurst},
                {4'd1, 3'd2, 2'd1});
        end
      end
      if (M_AWValid && M_AWReady) begin
        if (exp_aw.size() == 0) check("aw_unexpected", 1, 0);
        else begin
          a = exp_aw.pop_front();
          check("aw_addr", M_AWAddr, a.addr);
          check("aw_len", M_AWLen, a.len);
          check("aw_id_size_burst", {M_AWID, M_AWSize, M_AWBurst},
                {4'd1, 3'd2, 2'd1});
        end
      end
      if (M_WValid && M_WReady) begin
        if (exp_w.size() == 0) check("w_unexpected", 1, 0);
        else begin
          w = exp_w.pop_front();
          check("w_data", M_WData, w.data);
          check("w_last_strb", {M_WLast, M_WStrb}, {w.last, 4'hF});
        end
      end
      ar_hold = M_ARValid && !M_ARReady;
      ar_prev = {M_ARAddr, M_ARLen};
      aw_hold = M_AWValid && !M_AWReady;
      aw_prev = {M_AWAddr, M_AWLen};
      w_hold  = M_WValid && !M_WReady;
      w_prev  = {M_WData, M_WLast};
    end
  end

  task automatic wait_done(input int limit);
    int cyc = 0;
    while (!DMA_DONE && cyc < limit) begin
      @(negedge clk);
      #2;
      cyc++;
    end
    check("done_seen", DMA_DONE, 1);
    check("busy_at_done", DMA_BUSY, 0);
  endtask

  task automatic finish_xfer(input int hold);
    check("ar_drained", exp_ar.size(), 0);
    check("aw_drained", exp_aw.size(), 0);
    check("w_drained", exp_w.size(), 0);
    repeat (hold) begin
      @(negedge clk);
      #2;
      check("done_held", {DMA_DONE, DMA_BUSY}, 2'b10);
    end
    DMAEN = 0;
    @(negedge clk);
    #2;
    check("done_cleared", DMA_DONE, 0);
  endtask

  task automatic xfer(input logic [31:0] s, input logic [31:0] d,
                      input logic [31:0] n, input bit toggle,
                      input int hold);
    model(s, d, n);
    @(negedge clk);
    #2;
    DMASRC = s; DMADST = d; DMALEN = n; DMAEN = 1;
    if (toggle) begin
      repeat (3) @(negedge clk);
      #2;
      DMAEN = 0;
      DMASRC = $urandom; DMALEN = 32'($urandom_range(1, 5));
      @(negedge clk);
      #2;
      DMAEN = 1;
    end
    wait_done(3000);
    finish_xfer(hold);
  endtask

  initial begin
    int n;
    rst = 0; DMAEN = 0; DMASRC = 0; DMADST = 0; DMALEN = 0;
    seed = $urandom;
    repeat (3) @(negedge clk);
    #2;
    check("rst_status", {DMA_BUSY, DMA_DONE}, 0);
    check("rst_handshake", {M_ARValid, M_RReady, M_AWValid, M_WValid,
          M_BReady}, 0);
    rst = 1;

    xfer(32'h1000, 32'h2000, 4, 0, 0);
    xfer(32'h1000, 32'h2000, 20, 0, 0);

    @(negedge clk);
    #2;
    DMALEN = 0; DMAEN = 1;
    wait_done(2);
    finish_xfer(0);

    bp = 60;
    xfer(32'hFFFF_FFF3, 32'h0000_0102, 20, 0, 0);
    for (int i = 0; i < 8; i++) begin
      n = $urandom_range(1, 40);
      xfer($urandom, $urandom, 32'(n), 0, 0);
    end
    xfer(32'h3000, 32'h4000, 24, 1, 0);
    xfer(32'h5000, 32'h6000, 3, 0, 5);

    // Reset in the middle of the write phase of an 8-word copy.
    model(32'h7000, 32'h8000, 8);
    @(negedge clk);
    #2;
    DMASRC = 32'h7000; DMADST = 32'h8000; DMALEN = 8; DMAEN = 1;
    n = 0;
    while (!M_WValid && n < 500) begin
      @(negedge clk);
      #2;
      n++;
    end
    check("reached_wdata", M_WValid, 1);
    rst = 0;
    DMAEN = 0;
    @(posedge clk);
    #1;
    check("abort_status", {DMA_BUSY, DMA_DONE}, 0);
    check("abort_handshake", {M_ARValid, M_RReady, M_AWValid, M_WValid,
          M_BReady}, 0);
    exp_ar.delete(); exp_aw.delete(); exp_w.delete();
    repeat (2) @(negedge clk);
    #2;
    rst = 1;
    @(negedge clk);
    #2;
    check("idle_after_release", DMA_BUSY, 0);
    xfer(32'h9000, 32'hA000, 8, 0, 0);
    xfer($urandom, $urandom, 17, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
